// File: rtl/i2s_capture_writer.sv
// Captures a fixed number of 16-bit stereo I2S frames from a WM8731 ADC
// and writes each frame as {left, right} to a BRAM port.
module i2s_capture_writer #(
  parameter int unsigned ADDR_W = 15
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              start,
  input  logic [ADDR_W-1:0] num_frames,
  input  logic              bclk,
  input  logic              adclrc,
  input  logic              adcdat,
  output logic [31:0]       bram_addrb,
  output logic [31:0]       bram_dinb,
  output logic [3:0]        bram_web,
  output logic              bram_enb,
  output logic              busy,
  output logic              done
);

  localparam int unsigned SAMPLE_W = 16;
  localparam int unsigned CNT_W    = 5;

  typedef enum logic [1:0] {
    IDLE,
    WAIT_FRAME,
    CAPTURE,
    DONE
  } state_t;

  logic [1:0]          bclk_sync;
  logic [1:0]          lrc_sync;
  logic [1:0]          dat_sync;
  logic                bclk_d;
  logic                lrc_prev;
  logic [CNT_W-1:0]    bit_cnt;
  logic [SAMPLE_W-1:0] shift_reg;
  logic [SAMPLE_W-1:0] left;

  state_t              state, state_nx;
  logic [ADDR_W-1:0]   idx, idx_nx;
  logic [ADDR_W-1:0]   len_m1, len_m1_nx;
  logic                wr_c;

  logic bclk_rise_c;
  logic lrc_c;
  logic dat_c;
  logic boundary_c;
  logic frame_evt_c;

  assign bclk_rise_c = bclk_sync[1] & ~bclk_d;
  assign lrc_c       = lrc_sync[1];
  assign dat_c       = dat_sync[1];
  assign boundary_c  = bclk_rise_c & (lrc_c != lrc_prev);
  // Start of a left channel means the right word of the frame just finished.
  assign frame_evt_c = boundary_c & ~lrc_c;

  // Two-flop synchronizers for the codec-domain signals plus bclk edge history
  always_ff @(posedge clk) begin
    if (!rstn) begin
      bclk_sync <= 2'b00;
      lrc_sync  <= 2'b00;
      dat_sync  <= 2'b00;
      bclk_d    <= 1'b0;
    end else begin
      bclk_sync <= {bclk_sync[0], bclk};
      lrc_sync  <= {lrc_sync[0], adclrc};
      dat_sync  <= {dat_sync[0], adcdat};
      bclk_d    <= bclk_sync[1];
    end
  end

  // Serial deserializer; the boundary bit is the I2S one-bclk delay slot and is dropped
  always_ff @(posedge clk) begin
    if (!rstn) begin
      lrc_prev  <= 1'b0;
      bit_cnt   <= '0;
      shift_reg <= '0;
      left      <= '0;
    end else if (bclk_rise_c) begin
      lrc_prev <= lrc_c;
      if (boundary_c) begin
        bit_cnt <= '0;
        if (lrc_c) begin
          left <= shift_reg;
        end
      end else if (bit_cnt < CNT_W'(SAMPLE_W)) begin
        shift_reg <= {shift_reg[SAMPLE_W-2:0], dat_c};
        bit_cnt   <= bit_cnt + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state  <= IDLE;
      idx    <= '0;
      len_m1 <= '0;
    end else begin
      state  <= state_nx;
      idx    <= idx_nx;
      len_m1 <= len_m1_nx;
    end
  end

  // Length is kept as N-1 so that num_frames = 0 wraps naturally to 2^ADDR_W frames
  always_comb begin
    state_nx  = state;
    idx_nx    = idx;
    len_m1_nx = len_m1;
    wr_c      = 1'b0;
    case (state)
      IDLE, DONE: begin
        if (start) begin
          state_nx  = WAIT_FRAME;
          idx_nx    = '0;
          len_m1_nx = num_frames - ADDR_W'(1);
        end
      end
      WAIT_FRAME: begin
        if (frame_evt_c) begin
          state_nx = CAPTURE;
        end
      end
      CAPTURE: begin
        if (frame_evt_c) begin
          wr_c   = 1'b1;
          idx_nx = idx + ADDR_W'(1);
          if (idx == len_m1) begin
            state_nx = DONE;
          end
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  // Right word is taken straight from the shift register in the event cycle
  always_ff @(posedge clk) begin
    if (!rstn) begin
      bram_addrb <= '0;
      bram_dinb  <= '0;
      bram_web   <= '0;
      bram_enb   <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      bram_enb <= wr_c;
      bram_web <= wr_c ? 4'hF : 4'h0;
      if (wr_c) begin
        bram_addrb <= 32'(idx);
        bram_dinb  <= {left, shift_reg};
      end
      busy <= (state_nx == WAIT_FRAME) || (state_nx == CAPTURE);
      done <= (state_nx == DONE);
    end
  end

endmodule

// File: tb/tb_i2s_capture_writer.sv
// Directed bench for i2s_capture_writer: a bit-banged I2S codec drives two
// instances (default width and ADDR_W = 2) and every BRAM write is logged.
module tb_i2s_capture_writer;

  logic        clk = 1'b0;
  logic        rstn;
  logic        start;
  logic [14:0] num_frames;
  logic        start2;
  logic [1:0]  num_frames2;
  logic        bclk;
  logic        adclrc;
  logic        adcdat;

  logic [31:0] bram_addrb, bram_dinb, bram_addrb2, bram_dinb2;
  logic [3:0]  bram_web, bram_web2;
  logic        bram_enb, busy, done, bram_enb2, busy2, done2;

  int passed = 0;
  int total  = 0;

  logic [31:0] wa[$], wd[$], ww[$];
  logic [31:0] wa2[$], wd2[$], ww2[$];

  always #5 clk = ~clk;

  i2s_capture_writer dut (
    .clk(clk), .rstn(rstn), .start(start), .num_frames(num_frames),
    .bclk(bclk), .adclrc(adclrc), .adcdat(adcdat),
    .bram_addrb(bram_addrb), .bram_dinb(bram_dinb), .bram_web(bram_web),
    .bram_enb(bram_enb), .busy(busy), .done(done)
  );

  i2s_capture_writer #(.ADDR_W(2)) dut2 (
    .clk(clk), .rstn(rstn), .start(start2), .num_frames(num_frames2),
    .bclk(bclk), .adclrc(adclrc), .adcdat(adcdat),
    .bram_addrb(bram_addrb2), .bram_dinb(bram_dinb2), .bram_web(bram_web2),
    .bram_enb(bram_enb2), .busy(busy2), .done(done2)
  );

  // Log every write cycle of both instances
  always @(negedge clk) begin
    if (bram_enb) begin
      wa.push_back(bram_addrb);
      wd.push_back(bram_dinb);
      ww.push_back(32'(bram_web));
    end
    if (bram_enb2) begin
      wa2.push_back(bram_addrb2);
      wd2.push_back(bram_dinb2);
      ww2.push_back(32'(bram_web2));
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) $display("FAIL %s: got %h expected %h", tag, obs, exp);
    else passed++;
  endtask

  task automatic check_wr(input bit second, input int i, input logic [31:0] a,
                          input logic [31:0] d);
    int n;
    n = second ? wa2.size() : wa.size();
    if (i >= n) begin
      check($sformatf("wr%0d_present", i), 32'(n), 32'(i + 1));
    end else if (second) begin
      check($sformatf("wr2_%0d_addr", i), wa2[i], a);
      check($sformatf("wr2_%0d_data", i), wd2[i], d);
      check($sformatf("wr2_%0d_web", i), ww2[i], 32'hF);
    end else begin
      check($sformatf("wr%0d_addr", i), wa[i], a);
      check($sformatf("wr%0d_data", i), wd[i], d);
      check($sformatf("wr%0d_web", i), ww[i], 32'hF);
    end
  endtask

  // One channel of 32 bclk periods; slot 0 carries a dummy 1 (the I2S delay bit)
  task automatic send_chan(input logic lr, input logic [31:0] w);
    logic [32:0] bits;
    bits = {1'b1, w};
    for (int k = 0; k < 32; k++) begin
      bclk   = 1'b0;
      adclrc = lr;
      adcdat = bits[32-k];
      #80;
      bclk = 1'b1;
      #80;
    end
  endtask

  task automatic send_frame(input logic [15:0] l, input logic [15:0] r);
    send_chan(1'b0, {l, 16'h0000});
    send_chan(1'b1, {r, 16'h0000});
  endtask

  task automatic pulse_start(input logic [14:0] nf);
    @(negedge clk);
    start      = 1'b1;
    num_frames = nf;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_addr"}, bram_addrb, 32'h0);
    check({tag, "_din"}, bram_dinb, 32'h0);
    check({tag, "_web"}, 32'(bram_web), 32'h0);
    check({tag, "_enb"}, 32'(bram_enb), 32'h0);
    check({tag, "_busy"}, 32'(busy), 32'h0);
    check({tag, "_done"}, 32'(done), 32'h0);
  endtask

  initial begin
    rstn        = 1'b0;
    start       = 1'b0;
    num_frames  = '0;
    start2      = 1'b0;
    num_frames2 = '0;
    bclk        = 1'b0;
    adclrc      = 1'b0;
    adcdat      = 1'b0;
    repeat (4) @(negedge clk);
    check_outputs_zero("rst");
    check("rst2_enb", 32'(bram_enb2), 32'h0);
    check("rst2_busy", 32'(busy2), 32'h0);
    rstn = 1'b1;
    repeat (2) @(negedge clk);

    // Three frames; the dummy frame only supplies the first right->left boundary
    pulse_start(15'd3);
    check("t1_busy", 32'(busy), 32'h1);
    check("t1_done", 32'(done), 32'h0);
    send_frame(16'hDEAD, 16'hBEEF);
    send_frame(16'h1234, 16'hABCD);
    send_frame(16'h0001, 16'h8000);
    send_frame(16'hFFFF, 16'h0000);
    send_frame(16'h5555, 16'h6666);
    send_frame(16'h7777, 16'h9999);
    check("t1_count", 32'(wa.size()), 32'd3);
    check_wr(1'b0, 0, 32'd0, 32'h1234ABCD);
    check_wr(1'b0, 1, 32'd1, 32'h00018000);
    check_wr(1'b0, 2, 32'd2, 32'hFFFF0000);
    check("t1_done_end", 32'(done), 32'h1);
    check("t1_busy_end", 32'(busy), 32'h0);
    check("t1_enb_idle", 32'(bram_enb), 32'h0);
    check("t1_addr_hold", bram_addrb, 32'd2);

    // 24-bit words truncated to their top 16 bits
    wa.delete(); wd.delete(); ww.delete();
    pulse_start(15'd1);
    check("t2_done_clr", 32'(done), 32'h0);
    send_chan(1'b0, 32'hA5A5A500);
    send_chan(1'b1, 32'h5A5A5A00);
    send_frame(16'h0F0F, 16'hF0F0);
    check("t2_count", 32'(wa.size()), 32'd1);
    check_wr(1'b0, 0, 32'd0, 32'hA5A55A5A);
    check("t2_done", 32'(done), 32'h1);

    // Start during a right channel: the partial frame must not be written
    wa.delete(); wd.delete(); ww.delete();
    send_chan(1'b0, 32'h11110000);
    fork
      send_chan(1'b1, 32'h22220000);
      begin #800; pulse_start(15'd1); end
    join
    send_frame(16'hCAFE, 16'hF00D);
    send_frame(16'h3333, 16'h4444);
    check("t3_count", 32'(wa.size()), 32'd1);
    check_wr(1'b0, 0, 32'd0, 32'hCAFEF00D);

    // Second start while capturing is ignored
    wa.delete(); wd.delete(); ww.delete();
    pulse_start(15'd2);
    fork
      send_frame(16'h0102, 16'h0304);
      begin #2000; pulse_start(15'd7); end
    join
    send_frame(16'h0506, 16'h0708);
    send_frame(16'h0A0A, 16'h0B0B);
    send_frame(16'h0C0C, 16'h0D0D);
    send_frame(16'h0E0E, 16'h0F0F);
    check("t4_count", 32'(wa.size()), 32'd2);
    check_wr(1'b0, 0, 32'd0, 32'h01020304);
    check_wr(1'b0, 1, 32'd1, 32'h05060708);
    check("t4_done", 32'(done), 32'h1);

    // One-cycle reset between the first and second write
    wa.delete(); wd.delete(); ww.delete();
    pulse_start(15'd3);
    send_frame(16'h1357, 16'h2468);
    fork
      send_frame(16'h9BDF, 16'hACE0);
      begin
        #1000;
        @(negedge clk);
        rstn = 1'b0;
        @(negedge clk);
        rstn = 1'b1;
        check_outputs_zero("t5_rst");
      end
    join
    send_frame(16'h4321, 16'h8765);
    send_frame(16'h1111, 16'h2222);
    send_frame(16'h3333, 16'h4444);
    check("t5_count", 32'(wa.size()), 32'd1);
    check_wr(1'b0, 0, 32'd0, 32'h13572468);
    check("t5_busy_after", 32'(busy), 32'h0);
    check("t5_done_after", 32'(done), 32'h0);

    // ADDR_W = 2, num_frames = 0 means four frames
    wa.delete(); wd.delete(); ww.delete();
    @(negedge clk);
    start2      = 1'b1;
    num_frames2 = 2'd0;
    @(negedge clk);
    start2 = 1'b0;
    check("t6_busy", 32'(busy2), 32'h1);
    send_frame(16'h1111, 16'h2222);
    send_frame(16'h3333, 16'h4444);
    send_frame(16'h5555, 16'h6666);
    send_frame(16'h7777, 16'h8888);
    send_frame(16'h9999, 16'hAAAA);
    send_frame(16'hBBBB, 16'hCCCC);
    check("t6_count", 32'(wa2.size()), 32'd4);
    check_wr(1'b1, 0, 32'd0, 32'h11112222);
    check_wr(1'b1, 1, 32'd1, 32'h33334444);
    check_wr(1'b1, 2, 32'd2, 32'h55556666);
    check_wr(1'b1, 3, 32'd3, 32'h77778888);
    check("t6_done", 32'(done2), 32'h1);
    check("t6_main_quiet", 32'(wa.size()), 32'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
